// File: rtl/lut_log_scale.sv
// Serial threshold search mapping an unsigned Q4.4 magnitude to a saturated floor(ln(x)) code,
// with valid/ready handshakes on the input and result sides.
module lut_log_scale #(
  parameter int DATA_W  = 8,
  parameter int EXP_W   = 4,
  parameter int MIN_EXP = -3,
  parameter int MAX_EXP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  log_int,
  output logic              zero,
  output logic              sat
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [EXP_W-1:0] MIN_CODE = EXP_W'(MIN_EXP);
  localparam logic [EXP_W-1:0] MAX_CODE = EXP_W'(MAX_EXP);

  state_e              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [DATA_W-1:0]   x_q, x_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [EXP_W-1:0]    log_int_q, log_int_d;
  logic                zero_q, zero_d;
  logic                sat_q, sat_d;
  logic                hit_s;

  // Thresholds are round(16*e^(i-2)) in Q4.4.
  function automatic logic [DATA_W-1:0] thr(input logic [2:0] i);
    case (i)
      3'd0:    thr = DATA_W'(8'd2);
      3'd1:    thr = DATA_W'(8'd6);
      3'd2:    thr = DATA_W'(8'd16);
      3'd3:    thr = DATA_W'(8'd43);
      default: thr = DATA_W'(8'd118);
    endcase
  endfunction

  // Next-state and result computation for the handshake/search FSM.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    x_d         = x_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    log_int_d   = log_int_q;
    zero_d      = zero_q;
    sat_d       = sat_q;
    hit_s       = (x_q >= thr(idx_q));
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d        = in_data;
          idx_d      = 3'd0;
          zero_d     = (in_data == {DATA_W{1'b0}});
          in_ready_d = 1'b0;
          state_d    = SEARCH;
        end else begin
          // in_ready comes up on the first edge after reset release.
          in_ready_d = 1'b1;
        end
      end
      SEARCH: begin
        if (hit_s) begin
          if (idx_q == 3'd4) begin
            log_int_d   = MAX_CODE;
            sat_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          log_int_d   = MIN_CODE + EXP_W'(idx_q);
          sat_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        idx_d       = 3'd0;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      x_q         <= {DATA_W{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      log_int_q   <= {EXP_W{1'b0}};
      zero_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      log_int_q   <= log_int_d;
      zero_q      <= zero_d;
      sat_q       <= sat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign log_int   = log_int_q;
  assign zero      = zero_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_lut_log_scale.sv
// Directed and randomized checks of lut_log_scale against an exponential-threshold reference model.
module tb_lut_log_scale;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] log_int;
  logic       zero;
  logic       sat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lut_log_scale dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .log_int   (log_int),
    .zero      (zero),
    .sat       (sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Number of rounded thresholds 16*e^k (k=-2..2) not exceeding x.
  function automatic int ref_n(input int x);
    int n;
    n = 0;
    for (int k = -2; k <= 2; k++) begin
      if (x >= $rtoi(16.0 * $exp(real'(k)) + 0.5)) n++;
    end
    return n;
  endfunction

  task automatic run_one(input int x, input int hold);
    int n, c, e;
    logic [3:0] el;
    n  = ref_n(x);
    c  = (n + 1 < 5) ? n + 1 : 5;
    el = 4'(n - 3);
    e  = 0;
    while (!in_ready && e < 4) begin
      @(negedge clk);
      e++;
    end
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = 8'(x);
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    e = 0;
    while (!out_valid && e < 8) begin
      @(posedge clk);
      @(negedge clk);
      e++;
    end
    chk("latency", 32'(e), 32'(c));
    chk("log_int", 32'(log_int), 32'(el));
    chk("zero", 32'(zero), 32'(x == 0));
    chk("sat", 32'(sat), 32'(n == 5));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_log", 32'(log_int), 32'(el));
      chk("hold_sat", 32'(sat), 32'(n == 5));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_log", 32'(log_int), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed points from the block description.
    run_one(16, 0);
    run_one(0, 0);
    run_one(117, 0);
    run_one(118, 0);
    run_one(255, 0);
    run_one(43, 3);

    // Reset in the middle of a search for x=200.
    in_valid = 1'b1;
    in_data  = 8'd200;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_log", 32'(log_int), 32'd0);
    chk("midrst_zero", 32'(zero), 32'd0);
    chk("midrst_sat", 32'(sat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("midrst_no_result", 32'(out_valid), 32'd0);
    end
    run_one(6, 0);

    // Full sweep with random back-pressure, then random magnitudes.
    for (int x = 0; x < 256; x++) run_one(x, int'($urandom_range(0, 2)));
    for (int i = 0; i < 40; i++) run_one(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
